// File: rtl/raif_pkg.sv
// Shared definitions for the RAIF read/write arbiter.
package raif_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 30; i++)
      if ((1 << i) < value) result = i + 1;
    return result;
  endfunction

endpackage

// File: rtl/raif_arb_dir.sv
// One arbitration direction: picks an owner, latches its addr/num, forwards grant/finish.
module raif_arb_dir
  import raif_pkg::*;
#(
  parameter int ADDR_WIDTH  = 28,
  parameter int NUM_WIDTH   = 10,
  parameter int CHANNEL_NUM = 4,
  parameter int PRIO_MODE   = 0,
  parameter int SEL_WIDTH   = clog2(CHANNEL_NUM)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [CHANNEL_NUM-1:0]            up_req,
  input  logic [ADDR_WIDTH*CHANNEL_NUM-1:0] up_addr,
  input  logic [NUM_WIDTH*CHANNEL_NUM-1:0]  up_num,
  output logic [CHANNEL_NUM-1:0]            up_grant,
  output logic [CHANNEL_NUM-1:0]            up_finish,
  output logic                              dn_req,
  output logic [ADDR_WIDTH-1:0]             dn_addr,
  output logic [NUM_WIDTH-1:0]              dn_num,
  input  logic                              dn_grant,
  input  logic                              dn_finish,
  output logic [SEL_WIDTH-1:0]              owner,
  output logic                              busy
);

  arb_state_e           state;
  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] winner;
  int                   idx;

  // Descending scans leave the highest-precedence requester as the final assignment.
  always_comb begin
    winner = '0;
    idx    = 0;
    if (PRIO_MODE != 0) begin
      for (int i = CHANNEL_NUM - 1; i >= 0; i--)
        if (up_req[SEL_WIDTH'(i)]) winner = SEL_WIDTH'(i);
    end else begin
      for (int i = CHANNEL_NUM; i >= 1; i--) begin
        idx = int'(ptr) + i;
        if (idx >= CHANNEL_NUM) idx = idx - CHANNEL_NUM;
        if (up_req[SEL_WIDTH'(idx)]) winner = SEL_WIDTH'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= SEL_WIDTH'(CHANNEL_NUM - 1);
      owner   <= '0;
      dn_req  <= 1'b0;
      dn_addr <= '0;
      dn_num  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|up_req) begin
            owner   <= winner;
            dn_addr <= up_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
            dn_num  <= up_num[winner*NUM_WIDTH +: NUM_WIDTH];
            dn_req  <= 1'b1;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dn_finish) begin
            dn_req <= 1'b0;
            if (PRIO_MODE == 0) ptr <= owner;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_BUSY);

  // Downstream strobes outside a burst must never reach a master.
  always_comb begin
    up_grant         = '0;
    up_finish        = '0;
    up_grant[owner]  = dn_grant & busy;
    up_finish[owner] = dn_finish & busy;
  end

endmodule

// File: rtl/raif_arb_rr.sv
// N-channel read/write arbiter in front of the DDR3 core; each direction arbitrates independently.
module raif_arb_rr
  import raif_pkg::*;
#(
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_ADDR_WIDTH = 28,
  parameter int NUM_WIDTH      = 10,
  parameter int CHANNEL_NUM    = 4,
  parameter int PRIO_MODE      = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [CHANNEL_NUM-1:0]                rd_req_,
  input  logic [APP_ADDR_WIDTH*CHANNEL_NUM-1:0] rd_addr_,
  input  logic [NUM_WIDTH*CHANNEL_NUM-1:0]      rd_num_,
  output logic [APP_DATA_WIDTH*CHANNEL_NUM-1:0] rd_data_,
  output logic [CHANNEL_NUM-1:0]                rd_grant_,
  output logic [CHANNEL_NUM-1:0]                rd_finish_,
  input  logic [CHANNEL_NUM-1:0]                wr_req_,
  input  logic [APP_ADDR_WIDTH*CHANNEL_NUM-1:0] wr_addr_,
  input  logic [NUM_WIDTH*CHANNEL_NUM-1:0]      wr_num_,
  input  logic [APP_DATA_WIDTH*CHANNEL_NUM-1:0] wr_data_,
  output logic [CHANNEL_NUM-1:0]                wr_grant_,
  output logic [CHANNEL_NUM-1:0]                wr_finish_,
  output logic                                  rd_req,
  output logic [APP_ADDR_WIDTH-1:0]             rd_addr,
  output logic [NUM_WIDTH-1:0]                  rd_num,
  input  logic [APP_DATA_WIDTH-1:0]             rd_data,
  input  logic                                  rd_grant,
  input  logic                                  rd_finish,
  output logic                                  wr_req,
  output logic [APP_ADDR_WIDTH-1:0]             wr_addr,
  output logic [NUM_WIDTH-1:0]                  wr_num,
  output logic [APP_DATA_WIDTH-1:0]             wr_data,
  input  logic                                  wr_grant,
  input  logic                                  wr_finish,
  output logic [clog2(CHANNEL_NUM)-1:0]         rd_owner,
  output logic [clog2(CHANNEL_NUM)-1:0]         wr_owner,
  output logic                                  rd_busy,
  output logic                                  wr_busy
);

  raif_arb_dir #(
    .ADDR_WIDTH (APP_ADDR_WIDTH),
    .NUM_WIDTH  (NUM_WIDTH),
    .CHANNEL_NUM(CHANNEL_NUM),
    .PRIO_MODE  (PRIO_MODE)
  ) u_rd (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_req   (rd_req_),
    .up_addr  (rd_addr_),
    .up_num   (rd_num_),
    .up_grant (rd_grant_),
    .up_finish(rd_finish_),
    .dn_req   (rd_req),
    .dn_addr  (rd_addr),
    .dn_num   (rd_num),
    .dn_grant (rd_grant),
    .dn_finish(rd_finish),
    .owner    (rd_owner),
    .busy     (rd_busy)
  );

  raif_arb_dir #(
    .ADDR_WIDTH (APP_ADDR_WIDTH),
    .NUM_WIDTH  (NUM_WIDTH),
    .CHANNEL_NUM(CHANNEL_NUM),
    .PRIO_MODE  (PRIO_MODE)
  ) u_wr (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_req   (wr_req_),
    .up_addr  (wr_addr_),
    .up_num   (wr_num_),
    .up_grant (wr_grant_),
    .up_finish(wr_finish_),
    .dn_req   (wr_req),
    .dn_addr  (wr_addr),
    .dn_num   (wr_num),
    .dn_grant (wr_grant),
    .dn_finish(wr_finish),
    .owner    (wr_owner),
    .busy     (wr_busy)
  );

  // Only the current/last owner's read slice carries data; the rest stay quiet.
  always_comb begin
    rd_data_ = '0;
    rd_data_[rd_owner*APP_DATA_WIDTH +: APP_DATA_WIDTH] = rd_data;
  end

  assign wr_data = wr_data_[wr_owner*APP_DATA_WIDTH +: APP_DATA_WIDTH];

endmodule
